// File: rtl/stage_sequencer.sv
// stage_sequencer
//
// Drives a chain of NUM_STAGES downstream stages in order, repeating the
// whole chain a programmable number of passes. For each stage the sequencer
// raises that stage's bit of stage_start for 1+DELAY_CYCLES cycles. It then
// waits for that stage's stage_finished level and advances to the next stage.
//
// Control protocol (level/pulse, no valid/ready pair):
//   start  - request a run. It is only looked at while idle (finished=1).
//            The run is accepted on the edge where start=1 and abort=0.
//            A start seen during a run is dropped, never queued.
//   abort  - while a run is active, cancels it on the next edge. If it
//            coincides with any other transition, the abort takes priority.
//   done / aborted - one-cycle pulses in the first idle cycle after a run
//            ends normally or by abort.
//
// Ports:
//   clock, reset          sole clock; synchronous active-high reset
//   start, abort          run control (see above)
//   iterations            number of passes, captured with start; 0 acts as 1
//   finished              high exactly while idle
//   done, aborted         completion pulses
//   stage_start           one-hot start strobe to the current stage
//   stage_finished        per-stage finished levels (only the current bit is used)
//   cur_stage, cur_iter   index of the active stage and of the current pass
//   fsm_state             current FSM state, exported for debug/checkers
//
// Every output comes straight from a flop. The "next" values are decoded
// combinationally and then registered.

module stage_sequencer #(
  parameter int NUM_STAGES   = 4,
  parameter int DELAY_CYCLES = 1,
  parameter int ITER_WIDTH   = 8,
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ITER_WIDTH-1:0] iterations,
  output logic                  finished,
  output logic                  done,
  output logic                  aborted,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_finished,
  output logic [SW-1:0]         cur_stage,
  output logic [ITER_WIDTH-1:0] cur_iter,
  output logic [2:0]            fsm_state
);

  localparam logic [2:0] S_STANDBY = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DELAY   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_ADVANCE = 3'd4;

  localparam int DW = $clog2(DELAY_CYCLES + 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

  logic [2:0]            state_q, state_d;
  logic [DW-1:0]         dly_q, dly_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic [ITER_WIDTH-1:0] iter_lat_q, iter_lat_d;
  logic                  finished_q, done_q, aborted_q;
  logic                  done_d, aborted_d;
  logic [NUM_STAGES-1:0] ss_q, ss_d;

  logic last_stage, last_pass;

  assign last_stage = (stage_q == LAST_STAGE);
  // iter_lat_q is never 0 (a request for 0 passes is latched as 1), so the
  // subtraction cannot wrap and all-ones is a legal pass count.
  assign last_pass  = (iter_q == (iter_lat_q - ITER_WIDTH'(1)));

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    stage_d    = stage_q;
    iter_d     = iter_q;
    iter_lat_d = iter_lat_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;

    case (state_q)
      S_STANDBY: begin
        if (start && !abort) begin
          state_d    = S_START;
          stage_d    = '0;
          iter_d     = '0;
          iter_lat_d = (iterations == '0) ? ITER_WIDTH'(1) : iterations;
        end
      end
      S_START: begin
        state_d = S_DELAY;
        dly_d   = DW'(DELAY_CYCLES);
      end
      S_DELAY: begin
        if (dly_q == DW'(1)) begin
          state_d = S_WAIT;
        end else begin
          dly_d = dly_q - DW'(1);
        end
      end
      S_WAIT: begin
        if (stage_finished[stage_q]) begin
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (!last_stage) begin
          stage_d = stage_q + SW'(1);
          state_d = S_START;
        end else if (!last_pass) begin
          stage_d = '0;
          iter_d  = iter_q + ITER_WIDTH'(1);
          state_d = S_START;
        end else begin
          state_d = S_STANDBY;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_STANDBY;
      end
    endcase

    // Abort beats every in-run transition. The indices freeze where the run
    // was cut off, so the aborted position stays visible while idle.
    if (abort && (state_q != S_STANDBY)) begin
      state_d   = S_STANDBY;
      stage_d   = stage_q;
      iter_d    = iter_q;
      dly_d     = dly_q;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end
  end

  // Strobe is decoded from the next state/stage so it lines up with the
  // registered state it belongs to.
  always_comb begin
    ss_d = '0;
    if ((state_d == S_START) || (state_d == S_DELAY)) begin
      ss_d = NUM_STAGES'(1) << stage_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_STANDBY;
      dly_q      <= '0;
      stage_q    <= '0;
      iter_q     <= '0;
      iter_lat_q <= ITER_WIDTH'(1);
      finished_q <= 1'b1;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      ss_q       <= '0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      stage_q    <= stage_d;
      iter_q     <= iter_d;
      iter_lat_q <= iter_lat_d;
      finished_q <= (state_d == S_STANDBY);
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      ss_q       <= ss_d;
    end
  end

  assign finished    = finished_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign stage_start = ss_q;
  assign cur_stage   = stage_q;
  assign cur_iter    = iter_q;
  assign fsm_state   = state_q;

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of downstream stages driven in order (>=1).
REQ-002 SHALL have parameter DELAY_CYCLES, default 1, cycles stage_start stays high after the START cycle (>=1).
REQ-003 SHALL have parameter ITER_WIDTH, default 8, width of iteration count.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clock  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  request a run; sampled only in STANDBY.
REQ-008 abort  input  1  cancel a run in progress.
REQ-009 iterations  input  ITER_WIDTH  passes over all stages; sampled with start; 0 treated as 1.
REQ-010 finished  output  1  high exactly while in STANDBY.
REQ-011 done  output  1  one-cycle pulse on normal completion.
REQ-012 aborted  output  1  one-cycle pulse on abort completion.
REQ-013 stage_start  output  NUM_STAGES  one-hot start strobe to the current stage.
REQ-014 stage_finished  input  NUM_STAGES  per-stage finished level.
REQ-015 cur_stage  output  max(1,clog2(NUM_STAGES))  index of active stage.
REQ-016 cur_iter  output  ITER_WIDTH  zero-based index of current pass.

Function
REQ-017 SHALL implement states STANDBY, START, DELAY, WAIT, ADVANCE; all outputs registered.
REQ-018 STANDBY: start=1 and abort=0 -> START next cycle; latch iterations (0 -> 1); cur_stage=0, cur_iter=0.
REQ-019 start while not in STANDBY SHALL be ignored; no queuing.
REQ-020 START: lasts 1 cycle -> DELAY; delay counter loaded with DELAY_CYCLES.
REQ-021 DELAY: lasts exactly DELAY_CYCLES cycles -> WAIT.
REQ-022 stage_start[cur_stage] SHALL be 1 exactly in START and DELAY (1+DELAY_CYCLES cycles); all other bits 0 always; all 0 in WAIT, ADVANCE, STANDBY.
REQ-023 WAIT: stay until stage_finished[cur_stage]=1, then -> ADVANCE; other stage_finished bits ignored.
REQ-024 ADVANCE (1 cycle): if cur_stage<NUM_STAGES-1, cur_stage+1 -> START.
REQ-025 ADVANCE, last stage, cur_iter<latched-1: cur_iter+1, cur_stage=0 -> START.
REQ-026 ADVANCE, last stage, final pass: -> STANDBY; done=1 in the first STANDBY cycle only.
REQ-027 finished SHALL be 0 from the cycle after accepted start until return to STANDBY.
REQ-028 abort=1 in any state other than STANDBY -> STANDBY next cycle; stage_start all 0 that cycle; aborted=1 first STANDBY cycle; done stays 0.
REQ-029 abort and start both high in STANDBY: abort wins, stay STANDBY, no pulse.
REQ-030 abort in the same cycle as a WAIT exit or final ADVANCE: abort wins.
REQ-031 cur_iter and cur_stage SHALL hold their last values in STANDBY until next accepted start.
REQ-032 Iteration compare SHALL be unsigned ITER_WIDTH; max value 2^ITER_WIDTH-1 passes without wrap.

Reset
REQ-033 reset=1 at a rising edge: state=STANDBY, finished=1, done=0, aborted=0, stage_start=0, cur_stage=0, cur_iter=0, latched iterations=1.
REQ-034 Reset mid-run SHALL override abort/start, produce no done/aborted pulse, and not assert stage_start the following cycle.
REQ-035 reset is idle-safe: start held high through reset release is accepted on the first non-reset cycle.

Verification (NUM_STAGES=3, DELAY_CYCLES=1, ITER_WIDTH=8; each stage model drops finished the cycle after seeing stage_start, raises it 2 cycles after stage_start falls)
REQ-036 start=1 one cycle, iterations=1 -> stage_start bits 001,010,100 each high 2 cycles, in order; finished low throughout; one done pulse; no aborted.
REQ-037 iterations=0 -> identical to iterations=1; iterations=3 -> 9 stage strobes, cur_iter 0,1,2, single done after the 9th WAIT exit.
REQ-038 abort asserted during stage 1 WAIT -> next cycle STANDBY, finished=1, aborted pulse, stage 2 never strobed, done=0.
REQ-039 start re-pulsed during run, and start+abort together in STANDBY -> both ignored; strobe sequence and pulse counts unchanged.
REQ-040 reset asserted in DELAY of stage 0 -> next cycle all outputs at REQ-033 values, no pulses; subsequent start runs a full clean sequence.
